// File: rtl/lfsr_pkg.sv
// Shared constants and the LFSR step function for the keystream blocks.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;

    // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1
    localparam int unsigned TAP_A = 7;
    localparam int unsigned TAP_B = 5;
    localparam int unsigned TAP_C = 4;
    localparam int unsigned TAP_D = 3;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h41;

    // FSM encodings kept as plain constants for legacy tooling
    localparam logic [0:0] ST_RUN        = 1'b0;
    localparam logic [0:0] ST_SEED_DRAIN = 1'b1;

    // One LFSR step: shift left, feedback into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        logic fb;
        fb = q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];
        return {q[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit keystream LFSR with seed load and zero-seed substitution.
module lfsr8_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_INIT = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state,
    output logic              err_zero_seed
);

    // Load wins over step; a zero seed would lock the LFSR, so substitute the default
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SEED_INIT;
            err_zero_seed <= 1'b0;
        end else if (load) begin
            if (seed == '0) begin
                state         <= SEED_INIT;
                err_zero_seed <= 1'b1;
            end else begin
                state         <= seed;
                err_zero_seed <= 1'b0;
            end
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/lfsr_keystream_arbiter.sv
// Round-robin sharing of one LFSR keystream between NREQ byte requesters.
module lfsr_keystream_arbiter
    import lfsr_pkg::*;
#(
    parameter int unsigned       NREQ         = 4,
    parameter int unsigned       IDW          = 2,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = lfsr_pkg::DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_valid,
    input  logic [7:0]        seed_data,
    output logic              seed_ready,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic [IDW-1:0]    out_id,
    input  logic              out_ready,
    output logic [7:0]        lfsr_state,
    output logic              err_zero_seed
);

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic            slot_free_c;
    logic            grant_en_c;
    logic            grant_found_c;
    logic [NREQ-1:0] grant_oh_c;
    logic [IDW-1:0]  grant_idx_c;
    logic [7:0]      grant_data_c;

    assign slot_free_c = !out_valid || out_ready;

    // Rotating priority: first valid index at or after rr_ptr, then wrap from 0
    always_comb begin
        grant_found_c = 1'b0;
        grant_oh_c    = '0;
        grant_idx_c   = '0;
        grant_data_c  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found_c && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
                grant_found_c = 1'b1;
                grant_oh_c[i] = 1'b1;
                grant_idx_c   = IDW'(i);
                grant_data_c  = req_data[i*8 +: 8];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found_c && req_valid[i]) begin
                grant_found_c = 1'b1;
                grant_oh_c[i] = 1'b1;
                grant_idx_c   = IDW'(i);
                grant_data_c  = req_data[i*8 +: 8];
            end
        end
    end

    // Seed has priority over bytes; wait in SEED_DRAIN while the output slot is blocked
    always_comb begin
        state_nxt  = state;
        seed_ready = 1'b0;
        grant_en_c = 1'b0;
        case (state)
            ST_RUN: begin
                if (seed_valid) begin
                    if (slot_free_c) begin
                        seed_ready = 1'b1;
                    end else begin
                        state_nxt = ST_SEED_DRAIN;
                    end
                end else if (slot_free_c && grant_found_c) begin
                    grant_en_c = 1'b1;
                end
            end
            ST_SEED_DRAIN: begin
                if (!seed_valid) begin
                    state_nxt = ST_RUN;
                end else if (slot_free_c) begin
                    seed_ready = 1'b1;
                    state_nxt  = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
        req_ready = grant_en_c ? grant_oh_c : '0;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Output slot and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else if (grant_en_c) begin
            out_valid <= 1'b1;
            out_data  <= grant_data_c ^ lfsr_state;
            out_id    <= grant_idx_c;
            rr_ptr    <= (grant_idx_c == IDW'(NREQ - 1)) ? '0 : grant_idx_c + IDW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    lfsr8_core #(
        .SEED_INIT (DEFAULT_SEED)
    ) u_lfsr (
        .clk           (clk),
        .rst_n         (rst_n),
        .step          (grant_en_c),
        .load          (seed_valid && seed_ready),
        .seed          (seed_data),
        .state         (lfsr_state),
        .err_zero_seed (err_zero_seed)
    );

endmodule
